// File: rtl/fb_data_sel_pipe.sv
// Enable-gated select/merge of NSRC source words behind a valid/ready stage with a 2-entry skid buffer.
// Optional multi-hot event counter built only when FB_DATA_SEL_ERRCNT_EN is defined.
`timescale 1ns/1ps
`ifndef FB_32BITS
`define FB_32BITS 32
`endif

module fb_data_sel_pipe #(
    parameter int DW   = `FB_32BITS,
    parameter int NSRC = 3,
    parameter int PRIO = 0,
    parameter int SW   = $clog2(NSRC)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NSRC-1:0]    en,
    input  logic [NSRC*DW-1:0] d,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DW-1:0]      out_data,
    output logic [SW-1:0]      out_sel,
    output logic               out_none,
    output logic               out_multi,
    output logic [7:0]         err_cnt
);

    typedef struct packed {
        logic [DW-1:0] data;
        logic [SW-1:0] sel;
        logic          none;
        logic          multi;
    } pkt_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t        state;
    pkt_t          main_q, skid_q, in_pkt;
    logic [DW-1:0] or_data, pr_data;
    logic [SW-1:0] low_sel;
    logic          acc, drain;

    // Walking downward leaves the lowest set enable as the final winner.
    always_comb begin
        or_data = '0;
        pr_data = '0;
        low_sel = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            or_data = or_data | (d[i*DW +: DW] & {DW{en[i]}});
            if (en[i]) begin
                pr_data = d[i*DW +: DW];
                low_sel = SW'(i);
            end
        end
    end

    always_comb begin
        in_pkt.data  = (PRIO != 0) ? pr_data : or_data;
        in_pkt.sel   = low_sel;
        in_pkt.none  = ~|en;
        in_pkt.multi = |(en & (en - NSRC'(1)));
    end

    assign acc   = in_valid && in_ready;
    assign drain = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                EMPTY: if (acc) begin
                    main_q    <= in_pkt;
                    out_valid <= 1'b1;
                    state     <= ONE;
                end
                ONE: begin
                    if (acc && drain) begin
                        main_q <= in_pkt;
                    end else if (acc) begin
                        skid_q   <= in_pkt;
                        in_ready <= 1'b0;
                        state    <= TWO;
                    end else if (drain) begin
                        out_valid <= 1'b0;
                        state     <= EMPTY;
                    end
                end
                TWO: if (drain) begin
                    // in_ready is low here, so only the skid entry moves up
                    main_q   <= skid_q;
                    in_ready <= 1'b1;
                    state    <= ONE;
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign out_data  = main_q.data;
    assign out_sel   = main_q.sel;
    assign out_none  = main_q.none;
    assign out_multi = main_q.multi;

`ifdef FB_DATA_SEL_ERRCNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_cnt <= '0;
        else if (acc && in_pkt.multi && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
    end
`else
    assign err_cnt = '0;
`endif

endmodule
